// File: rtl/output_record_arbiter.sv
// output_record_arbiter: merges the readback, service and hit-data record
// FIFOs into one 24-bit show-ahead stream for the output serializer.
// One source is granted per frame and frames are never interleaved. Hit
// data is force-granted after STARVE_LIMIT consecutive lower-index frames.
module output_record_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       srcEmpty,
  input  logic [2:0][24:0] srcData,
  output logic [2:0]       srcRead,
  input  logic [2:0]       enableMask,
  output logic             emptyFifo,
  output logic [23:0]      data,
  input  logic             readFifo,
  output logic [2:0]       grant,
  output logic             starveEvent
);

  localparam int unsigned NSRC  = 3;
  localparam int unsigned REC_W = 24;
  localparam int unsigned WORD_W = REC_W + 1;
  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(7);
  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);

  localparam logic [NSRC-1:0] G_READBACK = NSRC'(1);
  localparam logic [NSRC-1:0] G_SERVICE  = NSRC'(2);
  localparam logic [NSRC-1:0] G_HIT      = NSRC'(4);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [NSRC-1:0]   cand;
  logic              starve_due;
  logic              hold_free;
  logic              pop;
  logic [WORD_W-1:0] pop_word;

  // Pop strobe and popped-word mux; grant is one-hot so srcRead is too.
  always_comb begin
    srcRead    = '0;
    hold_free  = emptyFifo | readFifo;
    cand       = enableMask & ~srcEmpty;
    starve_due = (starve_cnt >= LIMIT) && cand[2];
    if (state == BUSY && hold_free) begin
      srcRead = grant & ~srcEmpty;
    end
    pop      = |srcRead;
    pop_word = ({WORD_W{srcRead[0]}} & srcData[0])
             | ({WORD_W{srcRead[1]}} & srcData[1])
             | ({WORD_W{srcRead[2]}} & srcData[2]);
  end

  // Arbitration FSM, starvation counter and the one-entry holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      emptyFifo   <= 1'b1;
      data        <= '0;
      starveEvent <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      starveEvent <= 1'b0;

      if (pop) begin
        data      <= pop_word[REC_W-1:0];
        emptyFifo <= 1'b0;
      end else if (readFifo) begin
        emptyFifo <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (|cand) begin
            state <= BUSY;
            if (starve_due) begin
              grant       <= G_HIT;
              starveEvent <= 1'b1;
              starve_cnt  <= '0;
            end else if (cand[0] || cand[1]) begin
              grant <= cand[0] ? G_READBACK : G_SERVICE;
              if (cand[2] && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
              end
            end else begin
              grant      <= G_HIT;
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          if (pop && pop_word[REC_W]) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_record_arbiter.sv
// Bench for output_record_arbiter: directed latency/priority/backpressure/
// starvation/gap/reset scenarios plus randomized preloaded-frame runs scored
// against a frame-level arbitration model.
module tb_output_record_arbiter;

  localparam int LIMIT = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       srcEmpty;
  logic [2:0][24:0] srcData;
  logic [2:0]       srcRead;
  logic [2:0]       enableMask;
  logic             emptyFifo;
  logic [23:0]      data;
  logic             readFifo;
  logic [2:0]       grant;
  logic             starveEvent;

  output_record_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .srcEmpty(srcEmpty), .srcData(srcData),
    .srcRead(srcRead), .enableMask(enableMask), .emptyFifo(emptyFifo),
    .data(data), .readFifo(readFifo), .grant(grant), .starveEvent(starveEvent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_starve = 0;
  logic [2:0] last_rd;
  logic [24:0] q0[$];
  logic [24:0] q1[$];
  logic [24:0] q2[$];
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_word(input int s, input logic [24:0] w);
    case (s)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  // Drive the source FIFO heads from the bench-side queues.
  task automatic refresh();
    srcEmpty[0] = (q0.size() == 0);
    srcEmpty[1] = (q1.size() == 0);
    srcEmpty[2] = (q2.size() == 0);
    srcData[0]  = (q0.size() != 0) ? q0[0] : 25'h0;
    srcData[1]  = (q1.size() != 0) ? q1[0] : 25'h0;
    srcData[2]  = (q2.size() != 0) ? q2[0] : 25'h0;
  endtask

  // One clock: sample at negedge, then apply pops just after the rising edge.
  task automatic tick();
    @(negedge clk);
    last_rd = srcRead;
    chk("rd_onehot", 32'($countones(srcRead) <= 1), 32'd1);
    if (readFifo && !emptyFifo) got_q.push_back(data);
    if (starveEvent) begin
      n_starve++;
      chk("starve_grant", 32'(grant), 32'h4);
    end
    @(posedge clk);
    #1;
    if (last_rd[0]) void'(q0.pop_front());
    if (last_rd[1]) void'(q1.pop_front());
    if (last_rd[2]) void'(q2.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    got_q.delete(); exp_q.delete();
    n_starve = 0;
    readFifo = 1'b0;
    enableMask = 3'b111;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int n, input int bound, input bit rand_rd);
    int c = 0;
    while (got_q.size() < n && c < bound) begin
      if (rand_rd) readFifo = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    readFifo = 1'b1;
    repeat (4) tick();
    chk("drain_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Frame-level model: all frames preloaded, so each arbitration decision
  // depends only on which enabled sources still have frames.
  logic [24:0] mw[3][32];
  int mlen[3];
  int mpos[3];

  task automatic model_run(output int starves);
    int cnt = 0;
    int g;
    bit c0, c1, c2, done;
    starves = 0;
    for (int s = 0; s < 3; s++) mpos[s] = 0;
    forever begin
      c0 = enableMask[0] && (mpos[0] < mlen[0]);
      c1 = enableMask[1] && (mpos[1] < mlen[1]);
      c2 = enableMask[2] && (mpos[2] < mlen[2]);
      if (!(c0 || c1 || c2)) break;
      if (cnt >= LIMIT && c2) begin
        g = 2; starves++; cnt = 0;
      end else if (c0 || c1) begin
        g = c0 ? 0 : 1;
        if (c2 && cnt < 7) cnt++;
      end else begin
        g = 2; cnt = 0;
      end
      done = 1'b0;
      while (!done) begin
        exp_q.push_back(mw[g][mpos[g]][23:0]);
        done = mw[g][mpos[g]][24];
        mpos[g]++;
      end
    end
  endtask

  initial begin
    logic [24:0] w[6];
    logic [24:0] snap[$];
    int exp_starves;
    int nf, fl;

    // Single hit frame and reset values
    reset = 1'b1;
    readFifo = 1'b0;
    enableMask = 3'b111;
    refresh();
    #12;
    chk("rst_empty", 32'(emptyFifo), 32'd1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_starve", 32'(starveEvent), 32'd0);
    chk("rst_read", 32'(srcRead), 32'd0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w[k] = {(k == 3), 24'hA00000 + 24'(k)};
      push_word(2, w[k]);
    end
    readFifo = 1'b1;
    refresh();
    chk("hit_c0_grant", 32'(grant), 32'd0);
    tick();
    chk("hit_c1_grant", 32'(grant), 32'h4);
    chk("hit_c1_empty", 32'(emptyFifo), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hit_empty", 32'(emptyFifo), 32'd0);
      chk("hit_data", 32'(data), 32'(w[k][23:0]));
      chk("hit_grant", 32'(grant), (k < 3) ? 32'h4 : 32'h0);
    end
    tick();
    chk("hit_end_empty", 32'(emptyFifo), 32'd1);

    // Priority: readback frame first, one idle cycle, then hit frame
    do_reset();
    push_word(0, {1'b0, 24'h000010}); push_word(0, {1'b1, 24'h000011});
    push_word(2, {1'b0, 24'h000020}); push_word(2, {1'b1, 24'h000021});
    exp_q = '{24'h000010, 24'h000011, 24'h000020, 24'h000021};
    readFifo = 1'b1;
    refresh();
    tick(); chk("pri_c1", 32'(grant), 32'h1);
    tick(); chk("pri_c2", 32'(grant), 32'h1);
    tick(); chk("pri_c3", 32'(grant), 32'h0);
    tick(); chk("pri_c4", 32'(grant), 32'h4);
    chk("pri_gap_nopop", 32'(last_rd), 32'd0);
    tick(); chk("pri_c5", 32'(grant), 32'h4);
    tick(); chk("pri_c6", 32'(grant), 32'h0);
    drain(4, 50, 1'b0);
    compare_stream("pri");

    // Backpressure: 5-cycle stall mid-frame
    do_reset();
    for (int k = 0; k < 6; k++) begin
      w[k] = {(k == 5), 24'hB00000 + 24'(k)};
      push_word(1, w[k]);
      exp_q.push_back(w[k][23:0]);
    end
    readFifo = 1'b1;
    refresh();
    repeat (3) tick();
    readFifo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", 32'(data), 32'(w[1][23:0]));
      chk("bp_hold_full", 32'(emptyFifo), 32'd0);
      tick();
      chk("bp_no_pop", 32'(last_rd), 32'd0);
    end
    readFifo = 1'b1;
    tick();
    chk("bp_resume_pop", 32'(last_rd), 32'h2);
    drain(6, 100, 1'b0);
    compare_stream("bp");

    // Starvation with limit 2
    do_reset();
    for (int k = 0; k < 6; k++) push_word(0, {1'b1, 24'hC00000 + 24'(k)});
    push_word(2, {1'b1, 24'hD00000});
    push_word(2, {1'b1, 24'hD00001});
    exp_q = '{24'hC00000, 24'hC00001, 24'hD00000, 24'hC00002,
              24'hC00003, 24'hD00001, 24'hC00004, 24'hC00005};
    readFifo = 1'b1;
    refresh();
    drain(8, 200, 1'b0);
    compare_stream("starve");
    chk("starve_pulses", 32'(n_starve), 32'd2);

    // Mid-frame gap on source 1, then disable it
    do_reset();
    push_word(1, {1'b0, 24'hE00000});
    push_word(1, {1'b0, 24'hE00001});
    readFifo = 1'b1;
    refresh();
    repeat (5) tick();
    enableMask = 3'b101;
    push_word(0, {1'b1, 24'hF00000});
    refresh();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gap_grant_held", 32'(grant), 32'h2);
      chk("gap_no_pop", 32'(last_rd), 32'd0);
    end
    push_word(1, {1'b1, 24'hE00002});
    refresh();
    exp_q = '{24'hE00000, 24'hE00001, 24'hE00002, 24'hF00000};
    drain(4, 100, 1'b0);
    compare_stream("gap");
    push_word(1, {1'b1, 24'hE00003});
    refresh();
    repeat (10) tick();
    chk("gap_disabled_kept", 32'(q1.size()), 32'd1);
    chk("gap_idle", 32'(grant), 32'd0);

    // Asynchronous reset mid-frame
    do_reset();
    for (int k = 0; k < 5; k++) push_word(2, {(k == 4), 24'h700000 + 24'(k)});
    readFifo = 1'b1;
    refresh();
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_empty", 32'(emptyFifo), 32'd1);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_read", 32'(srcRead), 32'd0);
    snap = q2;
    got_q.delete();
    repeat (3) tick();
    chk("mrst_no_pop", 32'(q2.size()), 32'(snap.size()));
    reset = 1'b0;
    exp_q.delete();
    foreach (snap[i]) exp_q.push_back(snap[i][23:0]);
    drain(snap.size(), 100, 1'b0);
    compare_stream("mrst");

    // Randomized preloaded frames against the frame-level model
    for (int it = 0; it < 6; it++) begin
      do_reset();
      enableMask = 3'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) begin
        mlen[s] = 0;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          fl = $urandom_range(1, 4);
          for (int k = 0; k < fl; k++) begin
            mw[s][mlen[s]] = {(k == fl - 1), 24'($urandom)};
            push_word(s, mw[s][mlen[s]]);
            mlen[s]++;
          end
        end
      end
      model_run(exp_starves);
      refresh();
      drain(exp_q.size(), 2000, 1'b1);
      compare_stream("rand");
      chk("rand_starves", 32'(n_starve), 32'(exp_starves));
      for (int s = 0; s < 3; s++) chk("rand_left", 32'(qsize(s)), 32'(mlen[s] - mpos[s]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_record_arbiter.md
# output_record_arbiter

Merges the three FE-I4 emulator record sources (register readback, service records, hit data) into the single 24-bit record stream consumed by the output-data serializer block. Each source is a show-ahead FIFO whose words carry a frame-end flag. The block grants one source per frame, never interleaves frames, and enforces a starvation bound for hit data. It presents a show-ahead FIFO interface (`emptyFifo`/`data`/`readFifo`) that connects directly to the serializer's FIFO-side port and runs on the serializer's byte clock.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive non-hit frames allowed while hit source waits; legal 1..7.

Ports:
- `clk`  in  1  byte clock (serializer FIFO-side clock).
- `reset`  in  1  asynchronous, active-high.
- `srcEmpty`  in  3  per-source FIFO empty; bit 0 = readback (highest priority), 1 = service, 2 = hit data.
- `srcData`  in  3x25  per-source head word, `{last, record[23:0]}`, valid when `srcEmpty[i]`=0.
- `srcRead`  out  3  per-source pop strobe, one-hot or zero.
- `enableMask`  in  3  per-source enable; disabled sources are never newly granted.
- `emptyFifo`  out  1  output holding register empty.
- `data`  out  24  output head word; valid when `emptyFifo`=0.
- `readFifo`  in  1  consumer pop; ignored when `emptyFifo`=1.
- `grant`  out  3  one-hot current grant, 0 in IDLE.
- `starveEvent`  out  1  one-cycle pulse when a grant is forced by starvation.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: candidates are sources with `enableMask[i] & ~srcEmpty[i]`.
  - If the starve counter is at or above `STARVE_LIMIT` and source 2 is a candidate, grant source 2 and pulse `starveEvent`.
  - Otherwise grant the lowest-index candidate.
  - No candidate: stay in IDLE.
  - The grant is registered and the state moves to BUSY on the same edge.
- BUSY: pop the granted source (`srcRead[g]`=1) when `srcEmpty[g]`=0 and the holding register is free. Free means `emptyFifo`=1, or `readFifo`=1 this cycle.
  - The popped word is loaded into the holding register at the next edge.
  - Pop with `last`=1: return to IDLE at the same edge; `grant` clears.
  - Granted source empty mid-frame: stay in BUSY and wait. No switching, no timeout.
  - `enableMask[g]` deasserted mid-frame: the frame still completes.
- Holding register: 1 entry.
  - Loaded on pop, cleared on consumer read without simultaneous pop.
  - Simultaneous read and pop replaces the contents: 1 word/cycle throughput.
- Starve counter: 3 bits.
  - Increments, saturating at 7, on each grant to source 0 or 1 while source 2 is a candidate.
  - Clears on any grant to source 2.
  - Unchanged otherwise.
- At most one `srcRead` bit high per cycle; `srcRead` is never high in IDLE.

## Timing
- Reset values (asynchronous):
  - state IDLE, `grant`=0, `srcRead`=0, `emptyFifo`=1, `data`=0, `starveEvent`=0, starve counter 0.
- `srcRead` is combinational from state, grant, `srcEmpty`, `emptyFifo` and `readFifo`.
- All other outputs are registered.
- Latency: a source becomes non-empty in cycle 0 with the block in IDLE.
  - Grant registered at edge 1.
  - Pop in cycle 1.
  - `emptyFifo`=0 after edge 2.
- Frame gap: one IDLE cycle (no pop) between the `last` pop and the next frame's first pop.
- `readFifo` with `emptyFifo`=1: no effect.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost and sources are not popped further.
- `starveEvent` is high for exactly the cycle after the forced-grant edge.

## Test plan
- Single hit frame: source 2 holds 4 words (`last` on word 4), `readFifo` tied 1.
  - `data` sequence equals the 4 records on consecutive cycles from cycle 2.
  - `grant`=3'b100 for cycles 1-4, then 0.
- Priority: sources 0 and 2 both non-empty at cycle 0.
  - Source 0's frame completes entirely, then one IDLE cycle, then source 2's frame.
  - No interleaving.
- Backpressure: `readFifo`=0 for 5 cycles mid-frame.
  - Exactly one word is held, `srcRead`=0 during the stall, nothing is dropped or duplicated.
  - Streaming resumes the cycle `readFifo` returns to 1.
- Starvation with `STARVE_LIMIT`=2: source 0 continuously refilled with 1-word frames, source 2 non-empty.
  - Third grant goes to source 2 with `starveEvent` pulsed once.
  - Counter then restarts.
- Mid-frame gap and disable: source 1 goes empty after word 2 of 3 and `enableMask[1]` drops.
  - Block waits in BUSY, finishes word 3 when it arrives, then never regrants source 1.
- Reset mid-frame: assert `reset` asynchronously between edges.
  - `emptyFifo`=1, `grant`=0 and `srcRead`=0 immediately.
  - Normal arbitration resumes after release.
